// File: rtl/apb_slave_pkg.sv
// Shared definitions for the APB byte slave family.
//   - FSM state encodings (IDLE / WAIT / DONE) and the matching enum type
//   - WAIT_W: width of the wait-state counter (supports 0..15 wait states)
package apb_slave_pkg;

    localparam int WAIT_W = 4;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] WAIT_ENC = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        WAIT = WAIT_ENC,
        DONE = DONE_ENC
    } state_t;

endpackage

// File: rtl/apb_byte_slave_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and a byte slave.
//   master modport: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA,
//                   receives PRDATA/PREADY/PSLVERR
//   slave modport : the mirror image
interface apb_byte_slave_if #(
    parameter int APB_AW = 32,
    parameter int APB_DW = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_AW-1:0] PADDR;
    logic [APB_DW-1:0] PWDATA;
    logic [APB_DW-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_wait_counter.sv
// Loadable down-counter used to time APB wait states.
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; saturates at zero
//   is_one     : count currently equals 1
//   is_zero    : count currently equals 0
module apb_wait_counter
    import apb_slave_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              is_one,
    output logic              is_zero
);

    logic [WAIT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign is_one  = (cnt_reg == WAIT_W'(1));
    assign is_zero = (cnt_reg == '0);

endmodule

// File: rtl/apb_byte_slave.sv
// APB byte-wide register-array slave with configurable wait states.
//   clk  : clock, all logic on the rising edge
//   rst  : asynchronous active-high reset (array, FSM and outputs cleared)
//   bus  : APB slave modport (PSEL, PENABLE, PWRITE, PADDR, PWDATA in;
//          PRDATA, PREADY, PSLVERR out, all outputs registered)
// Addresses outside [BASE_ADDR, BASE_ADDR+DEPTH) complete with PSLVERR=1,
// never write the array and read back as zero.
module apb_byte_slave
    import apb_slave_pkg::*;
#(
    parameter int                APB_AW      = 32,
    parameter int                APB_DW      = 8,
    parameter int                DEPTH       = 16,
    parameter logic [APB_AW-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    apb_byte_slave_if.slave       bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [APB_AW:0] DEPTH_EXT = (APB_AW+1)'(DEPTH);

    // Live address decode of the setup phase.
    logic [APB_AW-1:0] offset;
    logic              addr_err;
    logic [IDX_W-1:0]  addr_idx;

    assign offset   = bus.PADDR - BASE_ADDR;
    assign addr_err = (bus.PADDR < BASE_ADDR) || ({1'b0, offset} >= DEPTH_EXT);
    assign addr_idx = offset[IDX_W-1:0];

    // Captured transfer attributes.
    state_t              state_reg;
    logic                write_reg;
    logic [APB_DW-1:0]   wdata_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                err_reg;
    logic                pready_reg;
    logic [APB_DW-1:0]   prdata_reg;
    logic                pslverr_reg;

    logic setup_seen;
    logic access_ok;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_is_one;
    logic cnt_is_zero;
    logic cnt_last;
    logic wr_en;

    assign setup_seen = bus.PSEL && !bus.PENABLE;
    assign access_ok  = bus.PSEL && bus.PENABLE;
    assign cnt_load   = (state_reg == IDLE) && setup_seen;
    // A zero count in WAIT cannot normally occur; treat it as "last" so the
    // FSM can never stall there.
    assign cnt_last   = cnt_is_one || cnt_is_zero;
    assign cnt_dec    = (state_reg == WAIT) && access_ok && !cnt_last;
    // Commit on the edge that closes the DONE cycle, only if the master is
    // still in the access phase.
    assign wr_en      = (state_reg == DONE) && access_ok && write_reg && !err_reg;

    apb_wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_W'(WAIT_CYCLES)),
        .dec      (cnt_dec),
        .is_one   (cnt_is_one),
        .is_zero  (cnt_is_zero)
    );

    // Byte array: one register per entry, each with its own write decode.
    logic [APB_DW-1:0] rd_bytes [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_byte
        logic [APB_DW-1:0] byte_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                byte_reg <= '0;
            end else if (wr_en && (idx_reg == IDX_W'(gi))) begin
                byte_reg <= wdata_reg;
            end
        end

        assign rd_bytes[gi] = byte_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            write_reg   <= 1'b0;
            wdata_reg   <= '0;
            idx_reg     <= '0;
            err_reg     <= 1'b0;
            pready_reg  <= 1'b0;
            prdata_reg  <= '0;
            pslverr_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (setup_seen) begin
                        write_reg <= bus.PWRITE;
                        wdata_reg <= bus.PWDATA;
                        idx_reg   <= addr_idx;
                        err_reg   <= addr_err;
                        if (WAIT_CYCLES == 0) begin
                            // No wait states: response comes straight from
                            // the live decode.
                            state_reg   <= DONE;
                            pready_reg  <= 1'b1;
                            prdata_reg  <= addr_err ? '0 : rd_bytes[addr_idx];
                            pslverr_reg <= addr_err;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!access_ok) begin
                        state_reg <= IDLE;
                    end else if (cnt_last) begin
                        state_reg   <= DONE;
                        pready_reg  <= 1'b1;
                        prdata_reg  <= err_reg ? '0 : rd_bytes[idx_reg];
                        pslverr_reg <= err_reg;
                    end
                end
                DONE: begin
                    state_reg   <= IDLE;
                    pready_reg  <= 1'b0;
                    prdata_reg  <= '0;
                    pslverr_reg <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.PREADY  = pready_reg;
    assign bus.PRDATA  = prdata_reg;
    assign bus.PSLVERR = pslverr_reg;

endmodule

// File: tb/tb_apb_byte_slave.sv
// Bench for apb_byte_slave: four instances with different wait-state and
// base-address settings share one stimulus driver; only the selected
// instance (cur) sees PSEL. Expected responses come from a per-instance
// byte-array model plus the address-window rule.
module tb_apb_byte_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [7:0]  pwdata;
    int          cur;

    logic [3:0]      pready_v;
    logic [3:0]      pslverr_v;
    logic [3:0][7:0] prdata_v;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [4][16];

    always #5 clk = ~clk;

    function automatic int w_of(input int c);
        case (c)
            0:       return 1;
            1:       return 0;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int c);
        return (c == 2) ? 32'h100 : 32'h0;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        apb_byte_slave_if #(.APB_AW(32), .APB_DW(8)) bus_i ();

        assign bus_i.PSEL    = psel && (cur == gi);
        assign bus_i.PENABLE = penable;
        assign bus_i.PWRITE  = pwrite;
        assign bus_i.PADDR   = paddr;
        assign bus_i.PWDATA  = pwdata;

        apb_byte_slave #(
            .APB_AW      (32),
            .APB_DW      (8),
            .DEPTH       (16),
            .BASE_ADDR   (base_of(gi)),
            .WAIT_CYCLES (w_of(gi))
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_i)
        );

        assign pready_v[gi]  = bus_i.PREADY;
        assign pslverr_v[gi] = bus_i.PSLVERR;
        assign prdata_v[gi]  = bus_i.PRDATA;
    end

    typedef struct {
        int          cfg;
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 16; i++)
                mem_m[c][i] = 8'h00;
    endtask

    function automatic bit m_err(input int c, input logic [31:0] a);
        return (a < base_of(c)) || ((a - base_of(c)) >= 32'd16);
    endfunction

    task automatic add_vec(input int c, input bit wr, input logic [31:0] a,
                           input logic [7:0] wd, input logic [7:0] erd, input bit ee);
        vec_t v;
        v.cfg = c; v.wr = wr; v.addr = a; v.wd = wd; v.exp_rd = erd; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the closing edge.
    task automatic xfer(input int c, input bit wr, input logic [31:0] a,
                        input logic [7:0] wd, output logic [7:0] rd, output bit er);
        bit          e;
        logic [31:0] off;
        logic [7:0]  exp_rd;
        int          lat;
        bit          done;
        e      = m_err(c, a);
        off    = a - base_of(c);
        exp_rd = e ? 8'h00 : mem_m[c][off[3:0]];
        cur = c; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0; done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (pready_v[c]) begin
                lat = k; done = 1'b1;
            end else begin
                check("prdata_zero_while_waiting", 32'(prdata_v[c]), 32'h0);
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL pready_timeout cfg=%0d actual=no_pready expected=pready", c);
        end
        check("latency", lat, w_of(c) + 1);
        check("pslverr", 32'(pslverr_v[c]), 32'(e));
        if (!wr) check("prdata", 32'(prdata_v[c]), 32'(exp_rd));
        rd = prdata_v[c];
        er = pslverr_v[c];
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        check("pready_one_cycle", 32'(pready_v[c]), 32'h0);
        if (wr && !e) mem_m[c][off[3:0]] = wd;
        $display("xfer cfg=%0d %s addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 c, wr ? "WR" : "RD", a, wd, rd, er, lat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rd;
        bit          er;
        logic [31:0] a;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; cur = 0;
        model_reset();

        // Directed table: expected values written out by hand.
        add_vec(0, 1, 32'h3,   8'hA5, 8'h00, 0);
        add_vec(0, 0, 32'h3,   8'h00, 8'hA5, 0);
        add_vec(1, 1, 32'h0,   8'h11, 8'h00, 0);
        add_vec(1, 1, 32'h1,   8'h22, 8'h00, 0);
        add_vec(1, 1, 32'h2,   8'h33, 8'h00, 0);
        add_vec(1, 1, 32'h3,   8'h44, 8'h00, 0);
        add_vec(1, 0, 32'h0,   8'h00, 8'h11, 0);
        add_vec(1, 0, 32'h1,   8'h00, 8'h22, 0);
        add_vec(1, 0, 32'h2,   8'h00, 8'h33, 0);
        add_vec(1, 0, 32'h3,   8'h00, 8'h44, 0);
        add_vec(2, 1, 32'h110, 8'h99, 8'h00, 1);
        add_vec(2, 0, 32'h100, 8'h00, 8'h00, 0);
        add_vec(2, 0, 32'h0FF, 8'h00, 8'h00, 1);
        add_vec(2, 1, 32'h100, 8'h3C, 8'h00, 0);
        add_vec(2, 0, 32'h100, 8'h00, 8'h3C, 0);
        add_vec(2, 0, 32'h10F, 8'h00, 8'h00, 0);
        add_vec(2, 0, 32'h110, 8'h00, 8'h00, 1);

        repeat (2) @(posedge clk);
        #1;
        check("reset_pready",  32'(pready_v),  32'h0);
        check("reset_pslverr", 32'(pslverr_v), 32'h0);
        check("reset_prdata",  32'(prdata_v),  32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].cfg, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, er);
            check("vec_err", 32'(er), 32'(vecs[i].exp_err));
            if (!vecs[i].wr) check("vec_rdata", 32'(rd), 32'(vecs[i].exp_rd));
        end

        // Abort: PENABLE dropped in the second wait cycle of a 3-wait write.
        cur = 3; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h7; pwdata = 8'h5A;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1; penable = 1'b0;
        @(posedge clk); #1; psel = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_no_pready", 32'(pready_v[3]), 32'h0);
        end
        @(posedge clk); #1;
        xfer(3, 0, 32'h7, 8'h00, rd, er);
        check("abort_no_commit", 32'(rd), 32'h0);

        // Stray access phase with no setup.
        cur = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h5; pwdata = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stray_no_pready", 32'(pready_v[0]), 32'h0);
        end
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
        xfer(0, 0, 32'h5, 8'h00, rd, er);
        check("stray_no_write", 32'(rd), 32'h0);

        // Reset asserted while PREADY is high: outputs clear at once.
        cur = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h3;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("done_pready_before_rst", 32'(pready_v[0]), 32'h1);
        check("done_prdata_before_rst", 32'(prdata_v[0]), 32'hA5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pready", 32'(pready_v[0]), 32'h0);
        check("async_rst_prdata", 32'(prdata_v[0]), 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; rst = 1'b0;
        model_reset();

        // Reset during the wait state of a write to address 2.
        cur = 3; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h2; pwdata = 8'h77;
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("wait_rst_pready",  32'(pready_v),  32'h0);
        check("wait_rst_pslverr", 32'(pslverr_v), 32'h0);
        check("wait_rst_prdata",  32'(prdata_v),  32'h0);
        @(posedge clk); #1; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_pready", 32'(pready_v[3]), 32'h0);
        end
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
        xfer(3, 0, 32'h2, 8'h00, rd, er);
        check("rst_write_not_committed", 32'(rd), 32'h0);
        xfer(0, 0, 32'h3, 8'h00, rd, er);
        check("rst_clears_array", 32'(rd), 32'h0);

        // Randomized traffic against the model, all four instances.
        for (int c = 0; c < 4; c++) begin
            for (int n = 0; n < 30; n++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                a = base_of(c) + 32'($urandom_range(0, 19)) - 32'd2;
                xfer(c, 1'($urandom_range(0, 1)), a, 8'($urandom), rd, er);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_byte_slave.md
# apb_byte_slave

Memory-mapped APB slave sitting directly downstream of the AHB-to-APB bridge. It consumes the bridge's byte-wide APB transfers, one per beat. It holds a small byte-addressable register array and inserts a parameterised number of wait states. Out-of-range accesses are answered with PSLVERR, so the bridge's HRESP path is exercised.

## Interface
- APB_AW, 32, APB address width
- APB_DW, 8, APB data width; one array entry per address
- DEPTH, 16, number of bytes in the array (≥1, ≤2^APB_AW)
- BASE_ADDR, 0, first decoded byte address
- WAIT_CYCLES, 1, wait states inserted in the access phase (0..15)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- PSEL  in  1  slave select
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  APB_AW  byte address
- PWDATA  in  APB_DW  write data
- PRDATA  out  APB_DW  read data; valid only while PREADY=1
- PREADY  out  1  transfer completion
- PSLVERR  out  1  error response; valid only while PREADY=1

## Operation
- Decode: offset = PADDR − BASE_ADDR, unsigned, APB_AW bits. The error flag is set when PADDR < BASE_ADDR or offset ≥ DEPTH. Index = offset[clog2(DEPTH)-1:0].
- FSM states: IDLE, WAIT, DONE.
- IDLE: when PSEL=1 and PENABLE=0 is sampled, capture PADDR, PWRITE, PWDATA and the error flag, and load cnt = WAIT_CYCLES.
  - If WAIT_CYCLES = 0, go to DONE and set PREADY.
  - Otherwise, go to WAIT.
  - PENABLE=1 without a preceding setup phase is ignored.
- WAIT: if PSEL=0 or PENABLE=0 is sampled, abort to IDLE with no side effects.
  - Else, if cnt = 1, go to DONE, set PREADY, and load PRDATA/PSLVERR.
  - Else, decrement cnt.
- DONE: PREADY=1 for exactly one cycle.
  - On the closing edge, a write is performed if PSEL & PENABLE & captured write & !error.
  - Then return to IDLE and clear PREADY, PRDATA and PSLVERR.
- Read data: PRDATA = array[index] captured when PREADY is set. PRDATA = 0 on an error and in all cycles where PREADY=0.
- Error writes never modify the array. Error reads return 0.
- Reset: all array bytes = 0, FSM = IDLE, cnt = 0, PRDATA = 0, PREADY = 0, PSLVERR = 0. This holds at any point, including mid-transfer. An interrupted write does not commit.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Setup at cycle n means PREADY is high in cycle n+1+WAIT_CYCLES. The access phase is therefore WAIT_CYCLES+1 cycles long.
- Back-to-back transfers: a setup phase in the cycle after DONE is accepted immediately, with no idle cycle required.
- A write becomes visible to a read whose setup follows the DONE cycle.
- Reset assertion takes effect asynchronously. Deassertion is synchronous to clk, and the first setup is accepted on the first edge after deassertion.

## Structure
- Shared package apb_slave_pkg holds:
  - FSM state encoding localparams (IDLE=2'd0, WAIT=2'd1, DONE=2'd2)
  - the wait-count width constant WAIT_W=4
- Sub-module apb_wait_counter: a loadable down-counter with a reached-one/zero flag, reusable by future APB slaves.
- The top level holds the address decode, capture registers, the array and the output registers.

## Test plan
- WAIT_CYCLES=1: write 8'hA5 to address 3, then read address 3. PREADY rises 2 cycles after each setup, PRDATA=8'hA5, PSLVERR=0.
- WAIT_CYCLES=0: four back-to-back reads of addresses 0..3 after writing 11/22/33/44. Each completes in 2 cycles and the data matches in order.
- BASE_ADDR=32'h100, DEPTH=16:
  - write to 32'h110 gives PSLVERR=1 and PREADY=1, and array contents are unchanged
  - read of 32'h0FF gives PSLVERR=1 and PRDATA=0
- WAIT_CYCLES=3: drop PENABLE in the second wait cycle during a write of 8'h5A to address 7. The FSM returns to IDLE, PREADY never asserts, and a later read of address 7 returns 0.
- Assert rst during the wait state of a write to address 2. All outputs read 0 immediately, and a subsequent read of address 2 returns 0.
- A stray PENABLE=1 with PSEL=1 and no setup cycle produces no PREADY and no array change.
